// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// MULT/MULTU use radix-2 shift-add; DIV/DIVU use restoring division.
// Both run on operand magnitudes, and the signs are applied in FIN.
// Timing: the accepting edge latches the operands. The next edge raises busy.
// 32 iteration edges follow, then the FIN edge writes HI/LO, so the
// result lands on the 34th edge after acceptance.
//
//   state | meaning
//   IDLE  | waiting for start; mthi/mtlo moves allowed
//   MUL   | shift-add iterations (first cycle only raises busy)
//   DIV   | restoring-division iterations (first cycle only raises busy)
//   FIN   | sign correction, HI/LO write, done pulse
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  mag_a, mag_b, raw_a;
  logic [W-1:0]  acc_hi, acc_lo;
  logic          neg_q, neg_r, is_div, div_zero;

  logic          a_neg, b_neg;
  logic [W-1:0]  abs_a, abs_b;
  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic          div_ok;
  logic [W-1:0]  div_rem;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]  q_fix, r_fix;

  // Operand magnitudes, one iteration step of each algorithm, and sign fix-up.
  always_comb begin
    a_neg     = ~op[0] & src_a[W-1];
    b_neg     = ~op[0] & src_b[W-1];
    abs_a     = a_neg ? -src_a : src_a;
    abs_b     = b_neg ? -src_b : src_b;
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mag_a : '0)};
    div_shift = {acc_hi, acc_lo[W-1]};
    div_ok    = div_shift >= {1'b0, mag_b};
    // The true difference is below the divisor, so W bits are enough for it.
    div_rem   = div_shift[W-1:0] - mag_b;
    prod_fix  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    q_fix     = neg_q ? -acc_lo : acc_lo;
    r_fix     = neg_r ? -acc_hi : acc_hi;
  end

  // Sequencer, datapath registers and the architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      raw_a    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            raw_a    <= src_a;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            is_div   <= op[1];
            div_zero <= (src_b == '0);
            acc_hi   <= '0;
            acc_lo   <= op[1] ? abs_a : abs_b;
            cnt      <= '0;
            state    <= op[1] ? DIV : MUL;
          end else begin
            if (mthi) hi <= wd;
            if (mtlo) lo <= wd;
          end
        end
        MUL: begin
          if (!busy) begin
            busy <= 1'b1;
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[W-1:1]};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIN;
          end
        end
        DIV: begin
          if (!busy) begin
            busy <= 1'b1;
          end else begin
            acc_hi <= div_ok ? div_rem : div_shift[W-1:0];
            acc_lo <= {acc_lo[W-2:0], div_ok};
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) state <= FIN;
          end
        end
        FIN: begin
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (div_zero) begin
            hi <= raw_a;
            lo <= '1;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit. It runs directed scenarios and then random operations.
// Expected HI/LO values come from plain 64-bit arithmetic in the reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0, src_b = '0, wd = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] hi_m = '0, lo_m = '0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result of one operation, from integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] ps;
    logic [63:0] pu;
    int q, r;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin
        ps = 64'($signed(a)) * 64'($signed(b));
        h = ps[63:32];
        l = ps[31:0];
      end
      2'b01: begin
        pu = 64'(a) * 64'(b);
        h = pu[63:32];
        l = pu[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFFFFFF;
        end else if (o == 2'b10 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          h = 32'd0;
          l = 32'h80000000;
        end else if (o == 2'b10) begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          h = r;
          l = q;
        end else begin
          h = a % b;
          l = a / b;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit mt_at_start);
    logic [31:0] eh, el;
    int bc;
    bit early;
    model(o, a, b, eh, el);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (mt_at_start) begin mthi = 1'b1; mtlo = 1'b1; wd = $urandom; end
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
    chk("busy_at_accept", 64'(busy), 64'(0));
    bc = 0;
    early = 1'b0;
    for (int n = 1; n <= 34; n++) begin
      if (disturb && n == 5) begin
        start = 1'b1; mthi = 1'b1; wd = 32'h11111111;
        src_a = 32'h12345678; src_b = 32'h9; op = 2'b00;
      end
      if (disturb && n == 6) begin start = 1'b0; mthi = 1'b0; end
      @(posedge clk); #1;
      if (busy) bc++;
      if (n < 34 && done) early = 1'b1;
      if (n == 33) begin
        chk("hi_stable", 64'(hi), 64'(hi_m));
        chk("lo_stable", 64'(lo), 64'(lo_m));
      end
    end
    chk("done_pulse", 64'(done), 64'(1));
    chk("no_early_done", 64'(early), 64'(0));
    chk("busy_cycles", 64'(bc), 64'(33));
    chk("hi_result", 64'(hi), 64'(eh));
    chk("lo_result", 64'(lo), 64'(el));
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'(0));
    hi_m = eh;
    lo_m = el;
  endtask

  initial begin
    bit saw_done;
    logic [31:0] a, b;
    logic [1:0] o;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst = 1'b0;

    // Directed scenarios
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
    chk("s1_hi", 64'(hi), 64'hFFFFFFFF);
    chk("s1_lo", 64'(lo), 64'hFFFFFFEB);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("s2_hi", 64'(hi), 64'hFFFFFFFE);
    chk("s2_lo", 64'(lo), 64'h00000001);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    chk("s3_div_lo", 64'(lo), 64'hFFFFFFFD);
    chk("s3_div_hi", 64'(hi), 64'hFFFFFFFF);
    run_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
    chk("s3_divz_lo", 64'(lo), 64'hFFFFFFFF);
    chk("s3_divz_hi", 64'(hi), 64'd100);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'h80000007, 32'd0, 1'b0, 1'b0);
    run_op(2'b11, 32'hDEADBEEF, 32'd1234, 1'b1, 1'b0);
    run_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1);

    // Reset during a multiply: abort, no done, HI/LO cleared
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'h00012345; src_b = 32'hFFFF0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("s5_busy", 64'(busy), 64'(0));
    chk("s5_hi", 64'(hi), 64'(0));
    chk("s5_lo", 64'(lo), 64'(0));
    hi_m = '0;
    lo_m = '0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("s5_no_done", 64'(saw_done), 64'(0));
    run_op(2'b01, 32'd3, 32'd5, 1'b0, 1'b0);
    chk("s5_lo15", 64'(lo), 64'd15);
    chk("s5_hi0", 64'(hi), 64'd0);

    // Simultaneous mthi/mtlo in IDLE
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wd = 32'h28082002;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("s6_hi", 64'(hi), 64'h28082002);
    chk("s6_lo", 64'(lo), 64'h28082002);
    chk("s6_done", 64'(done), 64'(0));
    hi_m = 32'h28082002;
    lo_m = 32'h28082002;

    // Random operations with interleaved moves
    for (int k = 0; k < 24; k++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 17));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      run_op(o, a, b, bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        wd = $urandom;
        mthi = 1'($urandom_range(0, 1));
        mtlo = 1'($urandom_range(0, 1));
        if (mthi) hi_m = wd;
        if (mtlo) lo_m = wd;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        chk("rnd_mt_hi", 64'(hi), 64'(hi_m));
        chk("rnd_mt_lo", 64'(lo), 64'(lo_m));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
